mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter granting NCH request channels onto one shared memory port.
// Latency: grant registered one edge after req_valid is seen in IDLE; completion one edge after mem_rdy.
// Backpressure: one transaction in flight; requesters hold req_valid until their req_rdy pulse.
//
// Ports:
//   clock, reset          sole rising-edge clock; asynchronous active-high reset
//   req_valid/req_wen     per-channel request and write enable (bit i = channel i)
//   req_addr/req_wdata    channel i fields at [i*AW +: AW] / [i*DW +: DW]
//   req_rdy               one-cycle completion pulse to the granted channel
//   req_rdata             read data captured at completion, held until the next one
//   mem_valid/addr/wdata/wen  forwarded request, stable while the transaction is open
//   mem_rdata/mem_rdy     memory response; mem_rdy is a one-cycle pulse
//   err                   timeout abort pulse
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a transaction after TIMEOUT
// cycles without mem_rdy. Without it, BUSY waits indefinitely and err is tied low.
module mem_arb #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*DW-1:0] req_wdata,
  input  logic [NCH-1:0]    req_wen,
  output logic [NCH-1:0]    req_rdy,
  output logic [DW-1:0]     req_rdata,
  output logic              mem_valid,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              mem_wen,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_rdy,
  output logic              err
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] last_grant;
  logic [CW-1:0] grant;
  logic [CW-1:0] pick;
  logic          pick_vld;
  logic [CW-1:0] rr_idx;
  logic          load;
  logic          done;
  logic          abort;

  // Round-robin search starting one past the last grant. The final offset (NCH)
  // lands back on last_grant, so a lone requester always wins.
  always_comb begin
    pick     = last_grant;
    pick_vld = 1'b0;
    rr_idx   = '0;
    for (int off = 1; off <= NCH; off++) begin
      rr_idx = CW'((int'(last_grant) + off) % NCH);
      if (!pick_vld && req_valid[rr_idx]) begin
        pick     = rr_idx;
        pick_vld = 1'b1;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] to_cnt;
  logic          to_hit;

  // The counter holds the number of BUSY cycles already spent without mem_rdy;
  // the edge that would make it TIMEOUT is the abort edge.
  assign to_hit = (to_cnt == TW'(TIMEOUT - 1));
`else
  localparam int timeout_unused = TIMEOUT;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and transaction strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // mem_rdy takes priority over a timeout landing on the same edge.
        if (mem_rdy) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (to_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_valid is exactly "a transaction is open".
  assign mem_valid = (state == BUSY);

  // Request capture, grant bookkeeping and completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wen    <= 1'b0;
      req_rdy    <= '0;
      req_rdata  <= '0;
      grant      <= '0;
      last_grant <= CW'(NCH - 1);
    end else begin
      req_rdy <= '0;
      if (load) begin
        mem_addr   <= req_addr[pick*AW +: AW];
        mem_wdata  <= req_wdata[pick*DW +: DW];
        mem_wen    <= req_wen[pick];
        grant      <= pick;
        last_grant <= pick;
      end
      if (done) begin
        req_rdata <= mem_rdata;
      end
      if (done || abort) begin
        req_rdy[grant] <= 1'b1;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= abort;
      if (load) begin
        to_cnt <= '0;
      end else if (state == BUSY && !mem_rdy && !to_hit) begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
